// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: datapath width, the NOP encoding and the
// {pc, inst} queue entry used by fetch_queue and fetch_fifo.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries. DEPTH must be a power
// of two so the pointers wrap naturally; flush has priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned DATA_W = $bits(fetch_entry_t),
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok, mem_we;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign mem_we  = push_ok && !flush_i;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read
  // after it has been written, and leaving it out keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Credit-based instruction fetch queue between the fetch unit and decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight out when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = fetch_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc,
  input  logic            io_redirect,
  output logic            io_stall_en,
  output logic            io_imem_req,
  output logic [XLEN-1:0] io_imem_addr,
  input  logic [XLEN-1:0] io_imem_rdata,
  output logic            io_deq_valid,
  input  logic            io_deq_ready,
  output logic [XLEN-1:0] io_deq_pc,
  output logic [XLEN-1:0] io_deq_inst
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic            run_q;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [2*XLEN-1:0] fifo_rdata;
  logic [CNT_W:0]    credit_used;
  logic              resp_valid;
  logic              deq_valid;
  logic [XLEN-1:0]   head_pc, head_inst;

  // Outstanding responses are pre-charged against free slots so a response
  // can always be written when it arrives.
  assign credit_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign io_stall_en  = (credit_used >= (CNT_W + 1)'(DEPTH));
  assign io_imem_req  = run_q && !io_stall_en && !io_redirect;
  assign io_imem_addr = io_pc;

  assign resp_valid = inflight_q && !io_redirect;
  assign inflight_d = io_imem_req;
  assign pc_d       = io_imem_req ? io_pc : pc_q;

  always_comb begin
    deq_valid = 1'b0;
    head_pc   = fifo_rdata[2*XLEN-1:XLEN];
    head_inst = fifo_rdata[XLEN-1:0];
    fifo_push = resp_valid && !fifo_full;
    if (!io_redirect) begin
      if (!fifo_empty) begin
        deq_valid = 1'b1;
`ifdef FETCH_QUEUE_BYPASS_EN
      end else if (resp_valid) begin
        deq_valid = 1'b1;
        head_pc   = pc_q;
        head_inst = io_imem_rdata;
        fifo_push = !io_deq_ready;
`endif
      end
    end
    fifo_pop = deq_valid && io_deq_ready && !fifo_empty;
  end

  assign io_deq_valid = deq_valid;
  assign io_deq_pc    = deq_valid ? head_pc : '0;
  assign io_deq_inst  = deq_valid ? head_inst : XLEN'(NOP);

  // run_q keeps the request strobe low until the first edge after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(2 * XLEN)
  ) u_fifo (
    .clk    (clock),
    .rst_n  (reset),
    .flush_i(io_redirect),
    .push_i (fifo_push),
    .wdata_i({pc_q, io_imem_rdata}),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule
